// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_unit: loads the reset vector, fetches and packs 1/2-word instrs. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fetch_unit #(
  parameter int ADDR_W  = 21,
  parameter int IMM_BIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [15:0]       ir_out,
  output logic [15:0]       imm_out,
  output logic [31:0]       pc_out,
  output logic              valid_out
);

  typedef enum logic [1:0] {
    VEC0 = 2'd0,
    VEC1 = 2'd1,
    RUN  = 2'd2,
    IMM  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [15:0] ir_nx, imm_nx;
  logic [31:0] pc_out_nx;
  logic        valid_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= VEC0;
      pc        <= '0;
      ir_out    <= '0;
      imm_out   <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      ir_out    <= ir_nx;
      imm_out   <= imm_nx;
      pc_out    <= pc_out_nx;
      valid_out <= valid_nx;
    end
  end

  // The vector states address fixed words; otherwise the truncated PC.
  always_comb begin
    unique case (state)
      VEC0:    imem_addr = '0;
      VEC1:    imem_addr = ADDR_W'(1);
      default: imem_addr = pc[ADDR_W-1:0];
    endcase
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir_out;
    imm_nx    = imm_out;
    pc_out_nx = pc_out;
    valid_nx  = valid_out;
    unique case (state)
      VEC0: begin
        pc_nx    = {imem_data, pc[15:0]};
        state_nx = VEC1;
      end
      VEC1: begin
        pc_nx    = {pc[31:16], imem_data};
        state_nx = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_nx    = branch_target;
          valid_nx = 1'b0;
          imm_nx   = '0;
        end else if (!stall) begin
          ir_nx     = imem_data;
          pc_out_nx = pc;
          imm_nx    = '0;
          pc_nx     = pc + 32'd1;
          if (imem_data[IMM_BIT]) begin
            valid_nx = 1'b0;
            state_nx = IMM;
          end else begin
            valid_nx = 1'b1;
          end
        end
      end
      IMM: begin
        // A redirect here drops the half-assembled packet.
        if (branch_taken) begin
          pc_nx    = branch_target;
          valid_nx = 1'b0;
          state_nx = RUN;
        end else if (!stall) begin
          imm_nx   = imem_data;
          valid_nx = 1'b1;
          pc_nx    = pc + 32'd1;
          state_nx = RUN;
        end
      end
      default: state_nx = VEC0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage front end. Owns the 32-bit PC and drives the instruction-memory word address. Registers the fetched instruction and any immediate into the fetch/decode boundary.
- Loads the reset vector from instruction memory words 0 and 1. Assembles two-word instructions into one decode packet, so decode sees the opcode word and its immediate together.
- Honours stall from hazard detection and redirect from branch resolution.

Parameters:
- ADDR_W, 21, instruction-memory word-address width; the low ADDR_W bits of PC are used.
- IMM_BIT, 15, bit of the opcode word that marks a two-word (immediate-carrying) instruction when 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block immediately.
- imem_addr  out  ADDR_W  word address to instruction memory; equals PC[ADDR_W-1:0] combinationally.
- imem_data  in  16  instruction word; combinational read of imem_addr, valid in the same cycle.
- stall  in  1  hold request from hazard detection.
- branch_taken  in  1  redirect request from branch resolution.
- branch_target  in  32  new PC when branch_taken=1.
- ir_out  out  16  registered opcode word.
- imm_out  out  16  registered immediate word; 0 for one-word instructions.
- pc_out  out  32  address of the opcode word in ir_out.
- valid_out  out  1  ir_out/imm_out/pc_out form a real instruction; 0 means bubble.

Behaviour:
- States: VEC0, VEC1, RUN, IMM.
- Reset (reset=0, asynchronous):
  - state=VEC0, PC=0.
  - ir_out=0, imm_out=0, pc_out=0, valid_out=0.
- VEC0:
  - imem_addr=0.
  - Next edge: PC[31:16]<=imem_data, state<=VEC1.
  - stall and branch_taken are ignored.
- VEC1:
  - imem_addr=1.
  - Next edge: PC[15:0]<=imem_data, state<=RUN.
  - valid_out stays 0 through both vector states.
- RUN, priority order branch_taken > stall > normal:
  - branch_taken=1: PC<=branch_target, valid_out<=0, imm_out<=0, state stays RUN. The word on imem_data this cycle is discarded.
  - stall=1: PC, state and all outputs hold.
  - Normal, one-word instruction (imem_data[IMM_BIT]=0):
    - ir_out<=imem_data, pc_out<=PC, imm_out<=0.
    - valid_out<=1, PC<=PC+1.
  - Normal, two-word instruction (imem_data[IMM_BIT]=1):
    - ir_out<=imem_data, pc_out<=PC.
    - valid_out<=0, PC<=PC+1, state<=IMM.
- IMM, same priority:
  - branch_taken=1: PC<=branch_target, valid_out<=0, state<=RUN. The partially fetched instruction is dropped.
  - stall=1: hold everything, stay in IMM.
  - Normal: imm_out<=imem_data (bit IMM_BIT not examined), valid_out<=1, PC<=PC+1, state<=RUN.
- Latency:
  - One-word instruction: valid_out is 1 on the edge after it is fetched.
  - Two-word instruction: valid_out is 1 two edges after the opcode word is fetched, with pc_out = opcode address.
- Valid handshake:
  - valid_out is a registered level; it is 1 for exactly one non-stalled cycle per instruction.
  - Under stall it is held, and downstream re-samples the same packet.
- Arithmetic: PC+1 is 32-bit modulo. 0xFFFFFFFF wraps to 0. imem_addr truncates PC to ADDR_W bits with no error.
- Simultaneous branch_taken and stall: branch wins; PC redirects and the packet becomes a bubble.
- Reset asserted mid-instruction (including in IMM): immediate return to VEC0 with all outputs 0. After release the vector is re-read.

Test Plan:
- Vector load: M[0]=0x0000, M[1]=0x0020, reset pulse -> VEC0, VEC1, then imem_addr=0x20 on the third cycle; valid_out=0 until the first fetch completes.
- One-word stream: M[0x20..0x22]=0x1001,0x1002,0x1003 -> ir_out 0x1001/0x1002/0x1003 on consecutive cycles; pc_out 0x20/0x21/0x22; valid_out=1 each cycle; imm_out=0.
- Two-word: M[0x20]=0x8005, M[0x21]=0xBEEF -> a bubble cycle, then ir_out=0x8005, imm_out=0xBEEF, pc_out=0x20, valid_out=1; next fetch from 0x22.
- Stall in RUN and in IMM: stall=1 for 3 cycles at each point -> outputs and imem_addr constant; the sequence then resumes with no lost or duplicated instruction.
- Branch: branch_taken=1, target=0x40, asserted together with stall=1 while in IMM -> valid_out=0 next cycle; then ir_out=M[0x40] with pc_out=0x40.
- Wrap: PC forced to 0xFFFFFFFF via branch_target -> next PC is 0; async reset=0 mid-cycle -> outputs 0 before the next edge.
